// File: rtl/adc_channel_sequencer.sv
// Round-robin ADC channel sequencer: walks the enabled channels, captures the matching tagged sample and
// hands it downstream over valid/ready. Define ADC_AVG_EN to average 4 matching samples per channel.
module adc_channel_sequencer #(
    parameter int NUM_CH         = 8,
    parameter int SAMPLE_W       = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic                err_clr,
    output logic [3:0]          channel,
    input  logic                new_sample,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [3:0]          sample_channel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_channel,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                busy,
    output logic                frame_done,
    output logic                timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [3:0]          r_ptr;
    logic [NUM_CH-1:0]   r_mask;
    logic [TW-1:0]       r_tcnt;
    logic [3:0]          r_channel;
    logic                r_out_valid;
    logic [3:0]          r_out_channel;
    logic [SAMPLE_W-1:0] r_out_data;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_timeout_err;

    logic                w_tag_hit;
    logic                w_wait_live;
    logic                w_match_final;
    logic                w_accept_partial;
    logic                w_timeout;
    logic                w_hs;
    logic                w_last;
    logic [3:0]          w_pick;
    logic [SAMPLE_W-1:0] w_result;

`ifdef ADC_AVG_EN
    logic [SAMPLE_W+1:0] r_sum;
    logic [1:0]          r_acc_cnt;
    logic [SAMPLE_W+1:0] w_sum_nx;
`endif

    // Lowest enabled index at or after ptr, wrapping; scanning k downward lets the smallest offset win.
    function automatic logic [3:0] f_pick(input logic [NUM_CH-1:0] mask, input logic [3:0] ptr);
        logic [3:0] pick;
        int         idx;
        pick = 4'd0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (mask[idx]) begin
                pick = 4'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] f_top(input logic [NUM_CH-1:0] mask);
        logic [3:0] top;
        top = 4'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (mask[k]) begin
                top = 4'(k);
            end
        end
        return top;
    endfunction

    function automatic logic [3:0] f_wrap_inc(input logic [3:0] ch);
        return (int'(ch) >= NUM_CH - 1) ? 4'd0 : ch + 4'd1;
    endfunction

    assign w_tag_hit   = new_sample && (sample_channel == r_channel);
    assign w_wait_live = (r_state == ST_WAIT) && enable;
    assign w_hs        = (r_state == ST_OUTPUT) && r_out_valid && out_ready;
    assign w_last      = (r_channel == f_top(r_mask));
    assign w_pick      = f_pick(ch_mask, r_ptr);
    // Any accepted sample restarts the timeout, so a timeout can only fire on a cycle without one.
    assign w_timeout   = w_wait_live && !w_tag_hit && (r_tcnt == TMAX);

`ifdef ADC_AVG_EN
    assign w_sum_nx         = r_sum + {2'b00, sample};
    assign w_result         = w_sum_nx[SAMPLE_W+1:2];
    assign w_match_final    = w_wait_live && w_tag_hit && (r_acc_cnt == 2'd3);
    assign w_accept_partial = w_wait_live && w_tag_hit && (r_acc_cnt != 2'd3);
`else
    assign w_result         = sample;
    assign w_match_final    = w_wait_live && w_tag_hit;
    assign w_accept_partial = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nx = ST_SELECT;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (!enable || (ch_mask == {NUM_CH{1'b0}})) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    w_state_nx = ST_IDLE;
                end else if (w_match_final) begin
                    w_state_nx = ST_OUTPUT;
                end else if (w_timeout) begin
                    w_state_nx = ST_SELECT;
                end else begin
                    w_state_nx = ST_WAIT;
                end
            end
            ST_OUTPUT: begin
                if (w_hs) begin
                    w_state_nx = enable ? ST_SELECT : ST_IDLE;
                end else begin
                    w_state_nx = ST_OUTPUT;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Datapath, pointer, timeout counter and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr         <= 4'd0;
            r_mask        <= {NUM_CH{1'b0}};
            r_tcnt        <= {TW{1'b0}};
            r_channel     <= 4'd0;
            r_out_valid   <= 1'b0;
            r_out_channel <= 4'd0;
            r_out_data    <= {SAMPLE_W{1'b0}};
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
`ifdef ADC_AVG_EN
            r_sum         <= {(SAMPLE_W+2){1'b0}};
            r_acc_cnt     <= 2'd0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            r_busy       <= (w_state_nx != ST_IDLE);
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end else begin
                r_timeout_err <= r_timeout_err;
            end
            case (r_state)
                ST_SELECT: begin
                    if (enable && (ch_mask != {NUM_CH{1'b0}})) begin
                        r_channel <= w_pick;
                        r_mask    <= ch_mask;
                        r_tcnt    <= {TW{1'b0}};
`ifdef ADC_AVG_EN
                        r_sum     <= {(SAMPLE_W+2){1'b0}};
                        r_acc_cnt <= 2'd0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (w_match_final) begin
                        r_out_valid   <= 1'b1;
                        r_out_data    <= w_result;
                        r_out_channel <= r_channel;
                    end else if (w_accept_partial) begin
`ifdef ADC_AVG_EN
                        r_sum     <= w_sum_nx;
                        r_acc_cnt <= r_acc_cnt + 2'd1;
`endif
                        r_tcnt    <= {TW{1'b0}};
                    end else if (w_timeout) begin
                        r_ptr        <= f_wrap_inc(r_channel);
                        r_frame_done <= w_last;
                    end else if (enable) begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (w_hs) begin
                        r_out_valid  <= 1'b0;
                        r_ptr        <= f_wrap_inc(r_channel);
                        r_frame_done <= w_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign channel     = r_channel;
    assign out_valid   = r_out_valid;
    assign out_channel = r_out_channel;
    assign out_data    = r_out_data;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: doc/adc_channel_sequencer.md
Name: adc_channel_sequencer

Overview:
Round-robin scheduler for the shared ADC sample stream. It walks the channels enabled in a mask and drives the requested ADC channel. It accepts only the tagged sample that matches the current channel and hands each result downstream over a valid/ready interface, ahead of serial/BNC output. A per-channel timeout keeps a dead channel from stalling the frame.

Parameters:
NUM_CH, 8, number of schedulable channels (1..16); index 0..NUM_CH-1
SAMPLE_W, 10, ADC sample width
TIMEOUT_CYCLES, 4096, cycles spent in WAIT before a channel is skipped (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
enable  in  1  run sequencing when high
ch_mask  in  NUM_CH  channel enable mask, bit i = channel i
err_clr  in  1  clears timeout_err
channel  out  4  channel requested from the ADC
new_sample  in  1  one-cycle strobe, sample/sample_channel valid
sample  in  SAMPLE_W  ADC result
sample_channel  in  4  channel tag of sample
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_channel  out  4  channel of result
out_data  out  SAMPLE_W  result value
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse when a full pass of the mask ends
timeout_err  out  1  sticky, set on any channel timeout

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; state IDLE; pointer 0; timeout counter 0.
- States: IDLE, SELECT, WAIT, OUTPUT.
- IDLE: if enable=1, go to SELECT.
- SELECT (1 cycle):
  - If ch_mask=0 or enable=0, go to IDLE.
  - Otherwise pick the lowest enabled index >= pointer, wrapping past NUM_CH-1 to 0.
  - Register that index into channel, clear the timeout counter, go to WAIT.
  - ch_mask is sampled only here.
- WAIT:
  - Match is new_sample=1 with sample_channel==channel. On a match: capture out_data<=sample and out_channel<=channel, set out_valid=1, go to OUTPUT. out_valid is high the cycle after the strobe.
  - Non-matching samples are discarded silently.
  - The counter increments each WAIT cycle. At TIMEOUT_CYCLES-1 with no match: set timeout_err, produce no output, advance the pointer, go to SELECT.
  - A match and the timeout on the same cycle: the match wins, no error.
  - enable=0 aborts to IDLE at the next edge with no output. The pointer is kept.
- OUTPUT:
  - out_valid, out_data and out_channel are held stable until out_ready=1. channel is unchanged. Incoming samples are dropped.
  - On the cycle where out_valid and out_ready are both high: out_valid=0 next cycle and pointer<=channel+1, wrapping NUM_CH->0.
  - Then go to SELECT if enable=1, else IDLE. enable=0 never cancels a pending result.
- frame_done pulses for 1 cycle when the completed or skipped channel is the highest set bit of the mask latched in SELECT. This coincides with the handshake or timeout exit.
- timeout_err: cleared by err_clr; a set on the same cycle wins over the clear.
- busy is 0 only in IDLE.
- Throughput is at most one result per (SELECT + WAIT + OUTPUT) cycles, minimum 3 cycles per channel.

Optional Feature:
ADC_AVG_EN
- Defined: WAIT accumulates 4 matching samples into a SAMPLE_W+2-bit sum. out_data = sum >> 2 (truncate). The timeout counter restarts after each accepted sample. A timeout discards the partial sum. Sum resets to 0 in SELECT.
- Undefined: the first matching sample is output directly, as above.

Test Plan:
1. Defaults, enable=1, ch_mask=0x05. Strobe ch0 with 0x155, then ch2 with 0x3FF, out_ready=1 -> results (0,0x155) then (2,0x3FF). channel goes 0 -> 2 -> 0. frame_done pulses once, with the ch2 handshake.
2. channel=2, strobe sample_channel=1 with 0x0AA -> no out_valid. Then strobe ch2 with 0x011 -> out_valid, out_data=0x011.
3. Hold out_ready=0 for 10 cycles after a result, with extra strobes -> out_valid/out_data/channel stable. Then out_ready=1 -> one handshake, extra samples lost.
4. TIMEOUT_CYCLES=16, ch_mask=0x03, no strobes on ch0 -> after 16 WAIT cycles timeout_err=1, channel becomes 1, no out_valid. err_clr pulse -> timeout_err=0.
5. Pull rst low mid-OUTPUT -> out_valid, channel, busy = 0 immediately, without waiting for a clock edge. After release, sequencing restarts at ch0.
6. ADC_AVG_EN defined, ch0 strobes 0x100, 0x101, 0x102, 0x103 -> single result out_data=0x101.
